// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with 2-stage tag pipeline, redirect, replay and halt
module pc_gen #(
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            inst_valid,
  output logic [PC_W-1:0] inst_pc,
  output logic            halted,
  output logic            misalign_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            s1_valid_q, s1_valid_d;
  logic [PC_W-1:0] s1_pc_q, s1_pc_d;
  logic            s2_valid_q, s2_valid_d;
  logic [PC_W-1:0] s2_pc_q, s2_pc_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;

  logic [PC_W-1:0] target_word;
  logic            unused_target_hi;

  assign target_word      = redirect_target[PC_W+1:2];
  assign unused_target_hi = ^redirect_target[31:PC_W+2];

  always_comb begin
    pc_d       = pc_q;
    s1_valid_d = !halted_q;
    s1_pc_d    = pc_q;
    s2_valid_d = s1_valid_q;
    s2_pc_d    = s1_pc_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;

    if (halted_q) begin
      // Frozen: pc held, redirects ignored, in-flight tags keep draining.
    end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
      halted_d   = 1'b1;
      s1_valid_d = 1'b0;
      s1_pc_d    = '0;
      s2_valid_d = 1'b0;
      s2_pc_d    = '0;
    end else if (redirect) begin
      pc_d       = target_word;
      s1_valid_d = 1'b0;
      s1_pc_d    = '0;
      s2_valid_d = 1'b0;
      s2_pc_d    = '0;
    end else if (halt_req) begin
      halted_d   = 1'b1;
      s1_valid_d = 1'b0;
    end else if (stall && s2_valid_q) begin
      // Unconsumed instruction at the output: refetch it and flush behind it.
      pc_d       = s2_pc_q;
      s1_valid_d = 1'b0;
      s1_pc_d    = '0;
      s2_valid_d = 1'b0;
      s2_pc_d    = '0;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= PC_W'(RESET_PC);
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_pc_q    <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
      s2_valid_q <= s2_valid_d;
      s2_pc_q    <= s2_pc_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign inst_valid   = s2_valid_q;
  assign inst_pc      = s2_pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt_req = 1'b0;
  logic [14:0] pc;
  logic        inst_valid;
  logic [14:0] inst_pc;
  logic        halted;
  logic        misalign_err;

  logic        rst2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_target2 = 32'h0;
  logic        halt_req2 = 1'b0;
  logic [3:0]  pc2;
  logic        inst_valid2;
  logic [3:0]  inst_pc2;
  logic        halted2;
  logic        misalign_err2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt_req(halt_req),
    .pc(pc), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .halted(halted), .misalign_err(misalign_err)
  );

  pc_gen #(.PC_W(4), .RESET_PC(14)) dut_w4 (
    .clk(clk), .rst(rst2), .stall(stall2), .redirect(redirect2),
    .redirect_target(redirect_target2), .halt_req(halt_req2),
    .pc(pc2), .inst_valid(inst_valid2), .inst_pc(inst_pc2),
    .halted(halted2), .misalign_err(misalign_err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    halt_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 15'd0) begin n_fail++; $display("FAIL reset_pc got %0h want 0", pc); end
    n_cmp++; if ({inst_valid, inst_pc} !== 16'h0) begin n_fail++; $display("FAIL reset_inst got v=%0b pc=%0h want v=0 pc=0", inst_valid, inst_pc); end
    n_cmp++; if ({halted, misalign_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {halted, misalign_err}); end
  endtask

  task automatic test_free_run();
    do_reset();
    n_cmp++; if ({pc, inst_valid} !== {15'd0, 1'b0}) begin n_fail++; $display("FAIL run_start got pc=%0h v=%0b want pc=0 v=0", pc, inst_valid); end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++; if (pc !== 15'(k)) begin n_fail++; $display("FAIL run_pc[%0d] got %0h want %0h", k, pc, k); end
      n_cmp++; if (inst_valid !== (k >= 2)) begin n_fail++; $display("FAIL run_valid[%0d] got %0b want %0b", k, inst_valid, (k >= 2)); end
      if (k >= 2) begin
        n_cmp++; if (inst_pc !== 15'(k - 2)) begin n_fail++; $display("FAIL run_inst_pc[%0d] got %0h want %0h", k, inst_pc, k - 2); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (5) step();
    n_cmp++; if (pc !== 15'd5) begin n_fail++; $display("FAIL redir_pre_pc got %0h want 5", pc); end
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++; if ({pc, inst_valid} !== {15'h10, 1'b0}) begin n_fail++; $display("FAIL redir_pc0 got pc=%0h v=%0b want pc=10 v=0", pc, inst_valid); end
    step();
    n_cmp++; if ({pc, inst_valid} !== {15'h11, 1'b0}) begin n_fail++; $display("FAIL redir_pc1 got pc=%0h v=%0b want pc=11 v=0", pc, inst_valid); end
    step();
    n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 15'h10}) begin n_fail++; $display("FAIL redir_first got v=%0b pc=%0h want v=1 pc=10", inst_valid, inst_pc); end
  endtask

  task automatic test_stall_replay();
    do_reset();
    repeat (9) step();
    n_cmp++; if ({pc, inst_valid, inst_pc} !== {15'd9, 1'b1, 15'd7}) begin n_fail++; $display("FAIL stall_pre got pc=%0h v=%0b ipc=%0h want 9 1 7", pc, inst_valid, inst_pc); end
    stall = 1'b1;
    step();
    n_cmp++; if ({pc, inst_valid} !== {15'd7, 1'b0}) begin n_fail++; $display("FAIL stall_replay got pc=%0h v=%0b want pc=7 v=0", pc, inst_valid); end
    step();
    n_cmp++; if ({pc, inst_valid} !== {15'd8, 1'b0}) begin n_fail++; $display("FAIL stall_c2 got pc=%0h v=%0b want pc=8 v=0", pc, inst_valid); end
    step();
    n_cmp++; if ({pc, inst_valid, inst_pc} !== {15'd9, 1'b1, 15'd7}) begin n_fail++; $display("FAIL stall_c3 got pc=%0h v=%0b ipc=%0h want 9 1 7", pc, inst_valid, inst_pc); end
    stall = 1'b0;
    step();
    n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 15'd8}) begin n_fail++; $display("FAIL stall_after got v=%0b ipc=%0h want v=1 ipc=8", inst_valid, inst_pc); end
    step();
    n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 15'd9}) begin n_fail++; $display("FAIL stall_after2 got v=%0b ipc=%0h want v=1 ipc=9", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (4) step();
    n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 15'd2}) begin n_fail++; $display("FAIL rs_pre got v=%0b ipc=%0h want v=1 ipc=2", inst_valid, inst_pc); end
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h100;
    step();
    stall = 1'b0; redirect = 1'b0;
    n_cmp++; if ({pc, inst_valid} !== {15'h40, 1'b0}) begin n_fail++; $display("FAIL rs_pc got pc=%0h v=%0b want pc=40 v=0", pc, inst_valid); end
    repeat (2) step();
    n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 15'h40}) begin n_fail++; $display("FAIL rs_first got v=%0b ipc=%0h want v=1 ipc=40", inst_valid, inst_pc); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    n_cmp++; if ({halted, pc, inst_valid, inst_pc} !== {1'b1, 15'd4, 1'b1, 15'd3}) begin n_fail++; $display("FAIL halt_drain got h=%0b pc=%0h v=%0b ipc=%0h want 1 4 1 3", halted, pc, inst_valid, inst_pc); end
    step();
    n_cmp++; if ({halted, pc, inst_valid} !== {1'b1, 15'd4, 1'b0}) begin n_fail++; $display("FAIL halt_empty got h=%0b pc=%0h v=%0b want 1 4 0", halted, pc, inst_valid); end
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++; if ({halted, pc, inst_valid} !== {1'b1, 15'd4, 1'b0}) begin n_fail++; $display("FAIL halt_redir_ign got h=%0b pc=%0h v=%0b want 1 4 0", halted, pc, inst_valid); end
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (3) step();
    redirect = 1'b1; redirect_target = 32'h42;
    step();
    n_cmp++; if ({misalign_err, halted, pc, inst_valid} !== {1'b1, 1'b1, 15'd3, 1'b0}) begin n_fail++; $display("FAIL mis_set got m=%0b h=%0b pc=%0h v=%0b want 1 1 3 0", misalign_err, halted, pc, inst_valid); end
    redirect_target = 32'h80;
    step();
    redirect = 1'b0;
    step();
    n_cmp++; if ({misalign_err, halted, pc, inst_valid} !== {1'b1, 1'b1, 15'd3, 1'b0}) begin n_fail++; $display("FAIL mis_hold got m=%0b h=%0b pc=%0h v=%0b want 1 1 3 0", misalign_err, halted, pc, inst_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({misalign_err, halted, pc} !== {1'b0, 1'b0, 15'd0}) begin n_fail++; $display("FAIL mis_clear got m=%0b h=%0b pc=%0h want 0 0 0", misalign_err, halted, pc); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    rst2 = 1'b1;
    #1;
    n_cmp++; if ({pc2, inst_valid2} !== {4'd14, 1'b0}) begin n_fail++; $display("FAIL w4_reset got pc=%0h v=%0b want e 0", pc2, inst_valid2); end
    step();
    rst2 = 1'b0;
    step();
    n_cmp++; if (pc2 !== 4'd15) begin n_fail++; $display("FAIL w4_pc15 got %0h want f", pc2); end
    step();
    n_cmp++; if ({pc2, inst_valid2, inst_pc2} !== {4'd0, 1'b1, 4'd14}) begin n_fail++; $display("FAIL w4_wrap got pc=%0h v=%0b ipc=%0h want 0 1 e", pc2, inst_valid2, inst_pc2); end
    step();
    n_cmp++; if ({pc2, inst_valid2, inst_pc2} !== {4'd1, 1'b1, 4'd15}) begin n_fail++; $display("FAIL w4_pc1 got pc=%0h v=%0b ipc=%0h want 1 1 f", pc2, inst_valid2, inst_pc2); end
    #2 rst2 = 1'b1;
    #1;
    n_cmp++; if ({pc2, inst_valid2, inst_pc2, halted2, misalign_err2} !== {4'd14, 1'b0, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL w4_async_rst got pc=%0h v=%0b ipc=%0h want e 0 0", pc2, inst_valid2, inst_pc2); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_redirect();
    test_stall_replay();
    test_redirect_stall();
    test_halt();
    test_misalign();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
